// File: rtl/mux8_rr_scheduler_pkg.sv
// rtl/mux8_rr_scheduler_pkg.sv - shared constants, state type and one-hot helper for the scheduler
package mux8_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_scheduler_if.sv
// rtl/mux8_rr_scheduler_if.sv - request/grant/data bundle between requesters and the scheduler
interface mux8_rr_scheduler_if;
    import mux8_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data_in;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             gnt_valid;
    logic             data_out;

    modport master (output req, output data_in,
                    input gnt, input sel, input gnt_valid, input data_out);
    modport slave  (input req, input data_in,
                    output gnt, output sel, output gnt_valid, output data_out);
endinterface

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
// rtl/mux8_rr_scheduler_rr_pick8.sv - combinational rotating-priority finder over 8 requests
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] j;

    // Scan from the far end back toward ptr so the closest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = ptr + SEL_W'(k);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// rtl/mux8_rr_scheduler.sv - round-robin scheduler driving the select of a shared 8:1 mux
module mux8_rr_scheduler
    import mux8_sched_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux8_rr_scheduler_if.slave   bus
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             gnt_valid;

    logic             release_now;
    logic [SEL_W-1:0] search_ptr;
    logic             found;
    logic [SEL_W-1:0] win;

    assign release_now = (state == BUSY) &&
                         (!bus.req[sel] || hold_cnt == CNT_W'(MAX_HOLD));
    // On release the search must already see the rotated pointer.
    assign search_ptr  = release_now ? sel + 1'b1 : ptr;

    rr_pick8 u_pick (
        .req   (bus.req),
        .ptr   (search_ptr),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= onehot(win);
                        sel       <= win;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CNT_W'(1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr <= search_ptr;
                        if (found) begin
                            gnt      <= onehot(win);
                            sel      <= win;
                            hold_cnt <= CNT_W'(1);
                        end else begin
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                            state     <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.sel       = sel;
    assign bus.gnt_valid = gnt_valid;
    assign bus.data_out  = gnt_valid ? bus.data_in[sel] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb/tb_mux8_rr_scheduler.sv - self-checking bench with a behavioural round-robin model
module tb_mux8_rr_scheduler;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mux8_rr_scheduler_if bus();

    mux8_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: owner is the index holding the grant, -1 when nobody does.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_known = 1'b0;

    function automatic int winner(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0; m_known = 1'b1;
        end else if (m_known) begin
            if (m_owner < 0) begin
                w = winner(bus.req, m_ptr);
                if (w >= 0) begin m_owner = w; m_sel = w; m_hold = 1; end
            end else if (!bus.req[m_owner] || m_hold == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % 8;
                w = winner(bus.req, m_ptr);
                if (w >= 0) begin m_owner = w; m_sel = w; m_hold = 1; end
                else begin m_owner = -1; m_hold = 0; end
            end else begin
                m_hold = m_hold + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [7:0] eg;
        logic       ed;
        #1;
        if (m_known) begin
            eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
            ed = (m_owner >= 0) ? bus.data_in[m_sel] : 1'b0;
            check("model_gnt",       int'(bus.gnt),       int'(eg));
            check("model_sel",       int'(bus.sel),       m_sel);
            check("model_gnt_valid", int'(bus.gnt_valid), int'(m_owner >= 0));
            check("model_data_out",  int'(bus.data_out),  int'(ed));
        end
    end

    task automatic cyc(input logic r, input logic [7:0] rq, input logic [7:0] d);
        @(negedge clk);
        rst = r; bus.req = rq; bus.data_in = d;
        @(posedge clk);
        #2;
    endtask

    int exp_sel;

    initial begin
        rst = 1'b1; bus.req = 8'hFF; bus.data_in = 8'hFF;

        // Reset with every request and data bit high
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 8'hFF, 8'hFF);
            check("rst_gnt", int'(bus.gnt), 0);
            check("rst_sel", int'(bus.sel), 0);
            check("rst_valid", int'(bus.gnt_valid), 0);
            check("rst_dout", int'(bus.data_out), 0);
        end
        cyc(1'b0, 8'hFF, 8'hFF);
        check("post_rst_gnt", int'(bus.gnt), 8'h01);
        check("post_rst_sel", int'(bus.sel), 0);

        // Single request from IDLE, then drop it
        cyc(1'b0, 8'h00, 8'hFF);
        check("idle_valid", int'(bus.gnt_valid), 0);
        cyc(1'b0, 8'h04, 8'b11010110);
        check("single_gnt", int'(bus.gnt), 8'h04);
        check("single_sel", int'(bus.sel), 2);
        check("single_dout", int'(bus.data_out), 1);
        cyc(1'b0, 8'h00, 8'b11010110);
        check("drop_gnt", int'(bus.gnt), 0);
        check("drop_valid", int'(bus.gnt_valid), 0);
        check("drop_sel", int'(bus.sel), 2);
        check("drop_dout", int'(bus.data_out), 0);

        // Full rotation, all requesting
        cyc(1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 36; i++) begin
            cyc(1'b0, 8'hFF, 8'hA5);
            exp_sel = (i / 4) % 8;
            check("rot_sel", int'(bus.sel), exp_sel);
            check("rot_valid", int'(bus.gnt_valid), 1);
        end

        // Two requesters at opposite ends of the ring
        cyc(1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 8'h81, 8'h80);
            exp_sel = (i >= 4 && i < 8) ? 7 : 0;
            check("fair_sel", int'(bus.sel), exp_sel);
        end

        // Sole requester re-granted across hold expiry without a gap
        cyc(1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h10, 8'h10);
            check("sole_gnt", int'(bus.gnt), 8'h10);
            check("sole_valid", int'(bus.gnt_valid), 1);
            check("sole_dout", int'(bus.data_out), 1);
        end

        // Early release hands straight over to the next requester
        cyc(1'b1, 8'h00, 8'h00);
        cyc(1'b0, 8'h28, 8'h00);
        check("early_gnt3", int'(bus.gnt), 8'h08);
        cyc(1'b0, 8'h28, 8'h00);
        check("early_hold", int'(bus.sel), 3);
        cyc(1'b0, 8'h20, 8'h00);
        check("handoff_gnt", int'(bus.gnt), 8'h20);
        check("handoff_sel", int'(bus.sel), 5);
        check("handoff_valid", int'(bus.gnt_valid), 1);

        // Reset in the middle of a grant
        cyc(1'b0, 8'h21, 8'h00);
        check("mid_gnt", int'(bus.gnt), 8'h20);
        cyc(1'b1, 8'h21, 8'h00);
        check("midrst_gnt", int'(bus.gnt), 0);
        check("midrst_valid", int'(bus.gnt_valid), 0);
        cyc(1'b0, 8'h21, 8'h00);
        check("midrst_regnt", int'(bus.gnt), 8'h01);
        check("midrst_sel", int'(bus.sel), 0);

        cyc(1'b0, 8'h00, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
